// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
//   Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is split
//   into STAGES chunks of CHUNK = WIDTH/STAGES bits. Stage k adds chunk k and
//   hands its carry to stage k+1. It also forwards the not-yet-added upper
//   operand bits (skew) and the already-finished lower sum bits (deskew).
//   Result: sum = A + (sub ? ~B : B) + (sub ? ~cin : cin), modulo 2^WIDTH.
//
// Parameters
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  pipeline depth (1 = single registered adder)
//
// Optional build macro
//   PIPE_ADDSUB_SAT_EN  when defined, the last stage clamps the sum to the
//                       most positive/negative value on signed overflow;
//                       out_cout/out_ovf still report the raw result.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   in_a, in_b          operands
//   in_cin              carry-in (add) / borrow-in (sub)
//   in_sub              0: A+B+cin, 1: A-B-cin
//   out_valid/out_ready result handshake
//   out_sum             result (wrapped, or saturated with the macro)
//   out_cout            carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   out_ovf             signed two's-complement overflow
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. A producer holding valid keeps its beat offered
// until it is taken. in_ready depends on out_ready and the stage valid bits
// only, never on in_valid. While out_valid is high and out_ready low, all
// out_* signals hold.
// -----------------------------------------------------------------------------
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    // Subtraction is addition of the inverted operand with inverted carry-in.
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = in_sub ? ~in_b : in_b;
    assign c0    = in_sub ? ~in_cin : in_cin;

    // ------------------------------------------------------------------
    // Valid chain. A stage loads when it is empty or its successor loads.
    // That lets bubbles collapse under a stall. in_ready falls only when
    // every stage holds a beat and the consumer is not taking one.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] stage_load;

    always_comb begin
        logic ld;
        stage_load = '0;
        ld         = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld            = !v_q[k] || ld;
            stage_load[k] = ld;
        end
    end

    always_comb begin
        v_in    = '0;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
        end
    end

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < STAGES; k++) begin
            if (stage_load[k]) begin
                v_d[k] = v_in[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready  = stage_load[0];
    assign out_valid = v_q[STAGES-1];

    // ------------------------------------------------------------------
    // Datapath stages
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // AW: operand bits still to be added, including this stage's chunk.
        // SW: sum bits known after this stage.
        localparam int AW = WIDTH - k * CHUNK;
        localparam int SW = (k + 1) * CHUNK;

        logic [AW-1:0]  a_src;
        logic [AW-1:0]  b_src;
        logic           c_src;
        logic [CHUNK:0] chunk_res;
        logic [SW-1:0]  sum_d;
        logic [SW-1:0]  sum_nx;
        logic [SW-1:0]  sum_q;
        logic           c_q;
        logic           load_en;

        if (k == 0) begin : g_src
            assign a_src = in_a;
            assign b_src = b_eff;
            assign c_src = c0;
            assign sum_d = chunk_res[CHUNK-1:0];
        end else begin : g_src
            assign a_src = g_stage[k-1].g_rem.rem_a_q;
            assign b_src = g_stage[k-1].g_rem.rem_b_q;
            assign c_src = g_stage[k-1].c_q;
            assign sum_d = {chunk_res[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        assign chunk_res = {1'b0, a_src[CHUNK-1:0]}
                         + {1'b0, b_src[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, c_src};

        // Data follows the valid bit. A stage that loads a bubble keeps its
        // old contents, so the outputs stay stable behind an empty slot.
        assign load_en = stage_load[k] && v_in[k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (load_en) begin
                sum_q <= sum_nx;
                c_q   <= chunk_res[CHUNK];
            end
        end

        if (k < STAGES - 1) begin : g_rem
            // Skew registers: upper operand chunks not yet added.
            logic [AW-CHUNK-1:0] rem_a_q;
            logic [AW-CHUNK-1:0] rem_b_q;

            assign sum_nx = sum_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_a_q <= '0;
                    rem_b_q <= '0;
                end else if (load_en) begin
                    rem_a_q <= a_src[AW-1:CHUNK];
                    rem_b_q <= b_src[AW-1:CHUNK];
                end
            end
        end else begin : g_last
            // Here a_src/b_src hold the top chunk, so their MSB is the
            // sign of A and of the effective B.
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = (a_src[AW-1] == b_src[AW-1])
                        && (sum_d[WIDTH-1] != a_src[AW-1]);

`ifdef PIPE_ADDSUB_SAT_EN
            // Overflow direction follows the sign of A: a positive A clamps
            // to 011..1 and a negative A clamps to 100..0.
            assign sum_nx = ovf_d ? {a_src[AW-1], {(WIDTH-1){~a_src[AW-1]}}}
                                  : sum_d;
`else
            assign sum_nx = sum_d;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (load_en) begin
                    ovf_q <= ovf_d;
                end
            end

            assign out_sum  = sum_q;
            assign out_cout = c_q;
            assign out_ovf  = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipe_addsub
//   Directed tests on an 8-bit, 2-stage instance: overflow, subtraction,
//   carry across the chunk boundary, back-pressure, reset mid-stream.
//   Random handshake streams on 32-bit instances with 4 stages and 1 stage.
//   Expected results are pushed to a queue on accept and compared on output.
// -----------------------------------------------------------------------------
module tb_pipe_addsub;

    localparam int NRAND = 10000;
`ifdef PIPE_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic, packed as {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin,
                                              input logic sub);
        logic [31:0] mask, bx, s;
        logic [32:0] full;
        logic        c0, cout, ovf, sa;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bx   = (sub ? ~b : b) & mask;
        c0   = sub ? ~cin : cin;
        full = {1'b0, a & mask} + {1'b0, bx} + {32'd0, c0};
        s    = full[31:0] & mask;
        cout = full[w];
        sa   = a[w-1];
        ovf  = (sa == bx[w-1]) && (s[w-1] != sa);
        if (SAT && ovf) s = sa ? (32'd1 << (w - 1)) : (mask >> 1);
        return {ovf, cout, s};
    endfunction

    function automatic logic [33:0] pk8(input logic ovf, input logic cout, input logic [7:0] s);
        return {ovf, cout, 24'd0, s};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- 8-bit, 2-stage DUT ----------------
    logic       d8_in_valid, d8_in_ready, d8_in_cin, d8_in_sub;
    logic       d8_out_valid, d8_out_ready, d8_out_cout, d8_out_ovf;
    logic [7:0] d8_in_a, d8_in_b, d8_out_sum;
    logic [33:0] d8_q[$];
    int          d8_fires = 0;

    pipe_addsub #(.WIDTH(8), .STAGES(2)) u_d8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d8_in_valid),
        .in_ready  (d8_in_ready),
        .in_a      (d8_in_a),
        .in_b      (d8_in_b),
        .in_cin    (d8_in_cin),
        .in_sub    (d8_in_sub),
        .out_valid (d8_out_valid),
        .out_ready (d8_out_ready),
        .out_sum   (d8_out_sum),
        .out_cout  (d8_out_cout),
        .out_ovf   (d8_out_ovf)
    );

    // scoreboard for the 8-bit instance
    always @(negedge clk) begin
        #1;
        if (rst_n && d8_out_valid && d8_out_ready) begin
            d8_fires++;
            check("d8_q_nonempty", d8_q.size() != 0, 1'b1);
            if (d8_q.size() != 0)
                check("d8_result", {d8_out_ovf, d8_out_cout, 24'd0, d8_out_sum}, d8_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic d8_drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic sub, input logic [33:0] exp);
        int waited = 0;
        @(negedge clk);
        d8_in_valid = 1'b1;
        d8_in_a     = a;
        d8_in_b     = b;
        d8_in_cin   = cin;
        d8_in_sub   = sub;
        #1;
        while (!d8_in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("d8_accept", d8_in_ready, 1'b1);
        if (d8_in_ready) d8_q.push_back(exp);
    endtask

    task automatic d8_single(input logic [7:0] a, input logic [7:0] b, input logic cin,
                             input logic sub, input logic [33:0] exp);
        int lat = 0;
        d8_out_ready = 1'b1;
        d8_drive(a, b, cin, sub, exp);
        do begin
            @(negedge clk);
            d8_in_valid = 1'b0;
            #1;
            lat++;
        end while (!d8_out_valid && lat < 20);
        check("d8_latency", lat, 2);
    endtask

    // ---------------- random 32-bit instances ----------------
    logic rand_go   = 1'b0;
    int   rand_done = 0;

    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int STG = (g == 0) ? 4 : 1;
        logic        in_valid, in_ready, in_cin, in_sub;
        logic        out_valid, out_ready, out_cout, out_ovf;
        logic [31:0] in_a, in_b, out_sum;
        logic [33:0] exp_q[$];

        pipe_addsub #(.WIDTH(32), .STAGES(STG)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_cin    (in_cin),
            .in_sub    (in_sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_sum   (out_sum),
            .out_cout  (out_cout),
            .out_ovf   (out_ovf)
        );

        initial begin
            int sent = 0;
            int got  = 0;
            int cyc  = 0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            in_a      = '0;
            in_b      = '0;
            in_cin    = 1'b0;
            in_sub    = 1'b0;
            wait (rand_go);
            while ((sent < NRAND || got < NRAND) && cyc < 60000) begin
                @(negedge clk);
                in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
                in_a      = pick_operand();
                in_b      = pick_operand();
                in_cin    = 1'($urandom_range(0, 1));
                in_sub    = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_model(32, in_a, in_b, in_cin, in_sub));
                    sent++;
                end
                if (out_valid && out_ready) begin
                    check($sformatf("rand_s%0d_q_nonempty", STG), exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0)
                        check($sformatf("rand_s%0d_result", STG),
                              {out_ovf, out_cout, out_sum}, exp_q.pop_front());
                    got++;
                end
                cyc++;
            end
            check($sformatf("rand_s%0d_received", STG), got, NRAND);
            rand_done++;
        end
    end

    // ---------------- directed sequence ----------------
    logic [7:0]  bp_a[5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    logic [7:0]  bp_b[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [33:0] bp_exp[5];

    initial begin
        int          idx;
        int          base;
        logic [7:0]  hold_sum;
        d8_in_valid  = 1'b0;
        d8_out_ready = 1'b1;
        d8_in_a      = '0;
        d8_in_b      = '0;
        d8_in_cin    = 1'b0;
        d8_in_sub    = 1'b0;
        hold_sum     = '0;
        for (int i = 0; i < 5; i++)
            bp_exp[i] = ref_model(8, {24'd0, bp_a[i]}, {24'd0, bp_b[i]}, 1'b0, i[0]);

        // reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", d8_out_valid, 1'b0);
        check("rst_out_sum", d8_out_sum, 8'h00);
        check("rst_out_cout", d8_out_cout, 1'b0);
        check("rst_out_ovf", d8_out_ovf, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", d8_in_ready, 1'b1);

        // arithmetic cases
        d8_single(8'h7F, 8'h01, 1'b0, 1'b0, pk8(1'b1, 1'b0, SAT ? 8'h7F : 8'h80));
        d8_single(8'h05, 8'h07, 1'b0, 1'b1, pk8(1'b0, 1'b0, 8'hFE));
        d8_single(8'h80, 8'h01, 1'b0, 1'b1, pk8(1'b1, 1'b1, SAT ? 8'h80 : 8'h7F));
        d8_single(8'h0F, 8'h01, 1'b1, 1'b0, pk8(1'b0, 1'b0, 8'h11));
        d8_single(8'hFF, 8'h00, 1'b1, 1'b0, pk8(1'b0, 1'b1, 8'h00));

        // back-pressure: consumer stalled, pipe fills after two beats
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            d8_out_ready = 1'b0;
            d8_in_valid  = 1'b1;
            d8_in_a      = bp_a[idx];
            d8_in_b      = bp_b[idx];
            d8_in_cin    = 1'b0;
            d8_in_sub    = idx[0];
            #1;
            if (c == 2) hold_sum = d8_out_sum;
            if (d8_in_ready) begin
                d8_q.push_back(bp_exp[idx]);
                idx++;
            end
        end
        check("bp_accepts", idx, 2);
        check("bp_in_ready_low", d8_in_ready, 1'b0);
        check("bp_out_valid", d8_out_valid, 1'b1);
        check("bp_hold_sum", d8_out_sum, hold_sum);
        check("bp_head", {d8_out_ovf, d8_out_cout, 24'd0, d8_out_sum}, bp_exp[0]);

        // release: remaining beats accepted, five results in five cycles
        base = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) base = d8_fires;
            d8_out_ready = 1'b1;
            d8_in_valid  = (idx < 5);
            if (idx < 5) begin
                d8_in_a   = bp_a[idx];
                d8_in_b   = bp_b[idx];
                d8_in_sub = idx[0];
            end
            #1;
            if (d8_in_valid && d8_in_ready) begin
                d8_q.push_back(bp_exp[idx]);
                idx++;
            end
        end
        @(negedge clk);
        d8_in_valid = 1'b0;
        check("bp_all_accepted", idx, 5);
        check("bp_drain_fires", d8_fires - base, 5);

        // reset with beats in flight
        d8_out_ready = 1'b1;
        d8_drive(8'h12, 8'h34, 1'b0, 1'b0, pk8(1'b0, 1'b0, 8'h46));
        d8_drive(8'h56, 8'h11, 1'b0, 1'b0, pk8(1'b0, 1'b0, 8'h67));
        @(negedge clk);
        rst_n       = 1'b0;
        d8_in_valid = 1'b0;
        d8_q.delete();
        #1;
        check("mid_rst_out_valid", d8_out_valid, 1'b0);
        check("mid_rst_out_sum", d8_out_sum, 8'h00);
        check("mid_rst_out_cout", d8_out_cout, 1'b0);
        check("mid_rst_out_ovf", d8_out_ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_in_ready", d8_in_ready, 1'b1);
        d8_single(8'h21, 8'h13, 1'b1, 1'b1, pk8(1'b0, 1'b1, 8'h0D));
        @(negedge clk);
        check("d8_q_drained", d8_q.size(), 0);

        // random streams on both 32-bit instances
        rand_go = 1'b1;
        wait (rand_done == 2);
        check("rand_s4_q_drained", g_rand[0].exp_q.size(), 0);
        check("rand_s1_q_drained", g_rand[1].exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
